// File: rtl/aes_dbg_pkg.sv
// Shared definitions for the AES debug probe.
//
// Contents:
//   - Mode encodings for the two-bit mode field of the switch bank.
//   - The capture FSM state type.
//   - Helper functions that locate each field inside the synchronised
//     switch word, given the channel-select width and the buffer index width.
//
// Switch word layout, LSB first:
//   sel  : [SEL_W-1:0]
//   mode : [SEL_W+1:SEL_W]
//   idx  : [SEL_W+2 +: IDX_W]
//   arm  : [SW_W-1]
package aes_dbg_pkg;

    localparam logic [1:0] MODE_LIVE     = 2'b00;
    localparam logic [1:0] MODE_FREEZE   = 2'b01;
    localparam logic [1:0] MODE_STATUS   = 2'b10;
    localparam logic [1:0] MODE_READBACK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } cap_state_e;

    // Lowest bit of the mode field
    function automatic int mode_lsb(input int sel_w);
        return sel_w;
    endfunction

    // Lowest bit of the readback index field
    function automatic int idx_lsb(input int sel_w);
        return sel_w + 2;
    endfunction

    // First bit above the index field (spare bits up to the arm switch)
    function automatic int spare_lsb(input int sel_w, input int idx_w);
        return sel_w + 2 + idx_w;
    endfunction

    // Width of the status word: cap_sel, state and wr_ptr (IDX_W+1 bits)
    function automatic int status_w(input int sel_w, input int idx_w);
        return sel_w + 2 + idx_w + 1;
    endfunction

endpackage

// File: rtl/aes_debug_probe_buf.sv
// Capture buffer for the AES debug probe.
//
// Simple dual-port RAM, DEPTH words of DATA_W bits, one write port and one
// read port with a registered output, written so synthesis maps it to
// on-chip block memory.  Contents are never reset.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, valid one cycle after raddr_i
module dbg_capture_buf #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port share the clock.  A read of the
    // address being written in the same cycle returns the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_debug_probe.sv
// AES debug probe.
//
// Picks one of CH_COUNT probe channels with the board switches and shows it
// on a registered debug word.  Besides the live view it can freeze a value,
// capture DEPTH beats of one channel after an arm edge, report capture
// status, and read the capture buffer back.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   ch_data         in   packed channels, channel k at [k*DATA_W +: DATA_W]
//   ch_valid        in   per-channel beat strobe
//   switch_entrada  in   raw asynchronous switch levels
//   debug_data      out  registered probe output
//   capture_done    out  high while the capture buffer is full
//   armed           out  high while a capture is in progress
//
// SW_W must be at least SEL_W+2+IDX_W+1 so the fields do not overlap.
module aes_debug_probe
    import aes_dbg_pkg::*;
#(
    parameter int CH_COUNT = 8,
    parameter int DATA_W   = 32,
    parameter int SW_W     = 18,
    parameter int DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH_COUNT*DATA_W-1:0] ch_data,
    input  logic [CH_COUNT-1:0]        ch_valid,
    input  logic [SW_W-1:0]            switch_entrada,
    output logic [DATA_W-1:0]          debug_data,
    output logic                       capture_done,
    output logic                       armed
);

    localparam int SEL_W    = $clog2(CH_COUNT);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = IDX_W + 1;
    localparam int MODE_LSB = mode_lsb(SEL_W);
    localparam int IDX_LSB  = idx_lsb(SEL_W);
    localparam int STAT_W   = status_w(SEL_W, IDX_W);

    // Switch synchroniser and decoded fields
    logic [SW_W-1:0]   sw_meta_q;
    logic [SW_W-1:0]   sw_s_q;
    logic [SW_W-1:0]   sw_s_d;
    logic              arm_prev_q;
    logic [1:0]        mode_prev_q;
    logic [SEL_W-1:0]  sel;
    logic [1:0]        mode;
    logic              arm_evt;
    logic [IDX_W-1:0]  rd_idx;
    logic              sw_unused;

    // Capture FSM
    cap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [SEL_W-1:0]  cap_sel_q, cap_sel_d;
    logic              armed_q, done_q;
    logic              buf_we;

    // Output path
    logic [DATA_W-1:0] live_word;
    logic [DATA_W-1:0] cap_word;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] freeze_q, freeze_d;
    logic [DATA_W-1:0] dbg_q, dbg_d;
    logic              freeze_entry;

    // Two-flop synchroniser for the raw switch levels, plus the delayed
    // copies of the arm and mode fields used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q   <= '0;
            sw_s_q      <= '0;
            arm_prev_q  <= 1'b0;
            mode_prev_q <= MODE_LIVE;
        end else begin
            sw_meta_q   <= switch_entrada;
            sw_s_q      <= sw_s_d;
            arm_prev_q  <= sw_s_q[SW_W-1];
            mode_prev_q <= mode;
        end
    end

    assign sw_s_d  = sw_meta_q;
    assign sel     = sw_s_q[SEL_W-1:0];
    assign mode    = sw_s_q[MODE_LSB +: 2];
    assign arm_evt = sw_s_q[SW_W-1] & ~arm_prev_q;

    // The buffer has a registered read port, so its address is taken from
    // the value sw_s is about to load.  The RAM output then lines up with
    // sw_s and readback keeps the same 3-cycle switch latency as the other
    // modes.
    assign rd_idx  = sw_s_d[IDX_LSB +: IDX_W];

    // The index and spare bits of sw_s itself are not decoded.
    assign sw_unused = ^sw_s_q[SW_W-2:IDX_LSB];

    assign live_word = ch_data[sel*DATA_W +: DATA_W];
    assign cap_word  = ch_data[cap_sel_q*DATA_W +: DATA_W];

    // Capture FSM state register.  armed/capture_done are registered copies
    // of the next state so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            cap_sel_q <= '0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cap_sel_q <= cap_sel_d;
            armed_q   <= (state_d == ST_ARMED);
            done_q    <= (state_d == ST_DONE);
        end
    end

    // Capture FSM next state.  An arm edge restarts capture from any state
    // and takes priority over a beat arriving in the same cycle, so that
    // beat is dropped.  The final write that fills the buffer moves to DONE
    // and wr_ptr stops at DEPTH.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cap_sel_d = cap_sel_q;
        buf_we    = 1'b0;
        if (arm_evt) begin
            cap_sel_d = sel;
            wr_ptr_d  = '0;
            state_d   = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (ch_valid[cap_sel_q]) begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + CNT_W'(1);
                        if (wr_ptr_q == CNT_W'(DEPTH - 1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    dbg_capture_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q[IDX_W-1:0]),
        .wdata_i (cap_word),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    // Status word, LSB-aligned: wr_ptr in the low bits, then state, then
    // the latched capture channel.
    always_comb begin
        status_word = '0;
        status_word[STAT_W-1:0] = {cap_sel_q, state_q, wr_ptr_q};
    end

    // Output mux.  On the first cycle of FREEZE the selected channel goes
    // both into the freeze register and straight to the output, so the
    // frozen value appears with the usual switch latency and then holds.
    assign freeze_entry = (mode == MODE_FREEZE) && (mode_prev_q != MODE_FREEZE);

    always_comb begin
        freeze_d = freeze_q;
        dbg_d    = dbg_q;
        if (freeze_entry) begin
            freeze_d = live_word;
        end
        case (mode)
            MODE_LIVE:     dbg_d = live_word;
            MODE_FREEZE:   dbg_d = freeze_entry ? live_word : freeze_q;
            MODE_STATUS:   dbg_d = status_word;
            MODE_READBACK: dbg_d = rd_data;
            default:       dbg_d = live_word;
        endcase
    end

    // Output and freeze registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freeze_q <= '0;
            dbg_q    <= '0;
        end else begin
            freeze_q <= freeze_d;
            dbg_q    <= dbg_d;
        end
    end

    assign debug_data   = dbg_q;
    assign capture_done = done_q;
    assign armed        = armed_q;

endmodule

// File: tb/tb_aes_debug_probe.sv
// Directed testbench for aes_debug_probe with default parameters
// (8 channels, 32-bit data, 18 switches, 16-deep buffer).
// Switch layout here: sel [2:0], mode [4:3], idx [8:5], arm [17].
module tb_aes_debug_probe;

    localparam int CH_COUNT = 8;
    localparam int DATA_W   = 32;
    localparam int SW_W     = 18;
    localparam int DEPTH    = 16;

    logic                       clk;
    logic                       rst;
    logic [CH_COUNT*DATA_W-1:0] ch_data;
    logic [CH_COUNT-1:0]        ch_valid;
    logic [SW_W-1:0]            switch_entrada;
    logic [DATA_W-1:0]          debug_data;
    logic                       capture_done;
    logic                       armed;

    int checks;
    int failures;

    aes_debug_probe #(
        .CH_COUNT (CH_COUNT),
        .DATA_W   (DATA_W),
        .SW_W     (SW_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_data        (ch_data),
        .ch_valid       (ch_valid),
        .switch_entrada (switch_entrada),
        .debug_data     (debug_data),
        .capture_done   (capture_done),
        .armed          (armed)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges and land 1 ns after the last one, where both
    // sampling and new stimulus happen.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sw(input int sel, input int mode, input int idx, input bit arm);
        logic [SW_W-1:0] w;
        w = '0;
        w[2:0]    = 3'(sel);
        w[4:3]    = 2'(mode);
        w[8:5]    = 4'(idx);
        w[SW_W-1] = arm;
        switch_entrada = w;
    endtask

    task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
        ch_data[k*DATA_W +: DATA_W] = v;
    endtask

    // Reset holds all outputs at zero
    task automatic test_reset();
        rst            = 1'b1;
        ch_data        = '0;
        ch_valid       = '0;
        switch_entrada = '0;
        tick(2);
        checks++;
        if (debug_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_debug actual=%h expected=%h", debug_data, 32'h0);
        end
        checks++;
        if (armed !== 1'b0 || capture_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags actual=%b%b expected=00", armed, capture_done);
        end
        rst = 1'b0;
        tick(2);
    endtask

    // Live view: 3-cycle switch latency, 1-cycle data latency
    task automatic test_live();
        set_ch(3, 32'hCAFE0003);
        set_sw(3, 0, 0, 1'b0);
        tick(2);
        checks++;
        if (debug_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL live_early actual=%h expected=%h", debug_data, 32'h0);
        end
        tick(1);
        checks++;
        if (debug_data !== 32'hCAFE0003) begin
            failures++;
            $display("[TB] FAIL live_sel3 actual=%h expected=%h", debug_data, 32'hCAFE0003);
        end
        set_ch(3, 32'h12345678);
        tick(1);
        checks++;
        if (debug_data !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL live_update actual=%h expected=%h", debug_data, 32'h12345678);
        end
    endtask

    // Freeze holds the value captured on entry until mode returns to live
    task automatic test_freeze();
        set_ch(2, 32'hAAAA0000);
        set_sw(2, 1, 0, 1'b0);
        tick(2);
        checks++;
        if (debug_data !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL freeze_early actual=%h expected=%h", debug_data, 32'h12345678);
        end
        tick(1);
        checks++;
        if (debug_data !== 32'hAAAA0000) begin
            failures++;
            $display("[TB] FAIL freeze_entry actual=%h expected=%h", debug_data, 32'hAAAA0000);
        end
        set_ch(2, 32'h55550000);
        tick(3);
        checks++;
        if (debug_data !== 32'hAAAA0000) begin
            failures++;
            $display("[TB] FAIL freeze_hold actual=%h expected=%h", debug_data, 32'hAAAA0000);
        end
        set_sw(2, 0, 0, 1'b0);
        tick(2);
        checks++;
        if (debug_data !== 32'hAAAA0000) begin
            failures++;
            $display("[TB] FAIL freeze_exit_early actual=%h expected=%h", debug_data, 32'hAAAA0000);
        end
        tick(1);
        checks++;
        if (debug_data !== 32'h55550000) begin
            failures++;
            $display("[TB] FAIL freeze_release actual=%h expected=%h", debug_data, 32'h55550000);
        end
    endtask

    // Arm on ch5, 20 beats, buffer fills after beat 16, readback checks
    task automatic test_capture();
        set_sw(5, 0, 0, 1'b0);
        tick(3);
        set_sw(5, 0, 0, 1'b1);
        tick(3);
        checks++;
        if (armed !== 1'b1 || capture_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cap_armed actual=%b%b expected=10", armed, capture_done);
        end
        for (int i = 1; i <= 20; i++) begin
            set_ch(5, 32'(i));
            ch_valid[5] = 1'b1;
            tick(1);
            if (i == 15) begin
                checks++;
                if (capture_done !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL cap_done_early actual=%b expected=0", capture_done);
                end
            end
            if (i == 16) begin
                checks++;
                if (capture_done !== 1'b1 || armed !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL cap_done actual=%b%b expected=01", armed, capture_done);
                end
            end
        end
        ch_valid = '0;
        // cap_sel=5, state=DONE(2), wr_ptr=16
        set_sw(5, 2, 0, 1'b1);
        tick(3);
        checks++;
        if (debug_data !== 32'h2D0) begin
            failures++;
            $display("[TB] FAIL cap_status actual=%h expected=%h", debug_data, 32'h2D0);
        end
        set_sw(5, 3, 0, 1'b1);
        tick(3);
        checks++;
        if (debug_data !== 32'd1) begin
            failures++;
            $display("[TB] FAIL rb_idx0 actual=%h expected=%h", debug_data, 32'd1);
        end
        set_sw(5, 3, 15, 1'b1);
        tick(3);
        checks++;
        if (debug_data !== 32'd16) begin
            failures++;
            $display("[TB] FAIL rb_idx15 actual=%h expected=%h", debug_data, 32'd16);
        end
        set_sw(5, 3, 7, 1'b1);
        tick(3);
        checks++;
        if (debug_data !== 32'd8) begin
            failures++;
            $display("[TB] FAIL rb_idx7 actual=%h expected=%h", debug_data, 32'd8);
        end
    endtask

    // Status mid-capture; sel change after arm does not move the capture
    task automatic test_status_mid();
        set_sw(5, 2, 0, 1'b0);
        tick(3);
        set_sw(5, 2, 0, 1'b1);
        tick(3);
        for (int i = 0; i < 5; i++) begin
            set_ch(5, 32'(100 + i));
            ch_valid[5] = 1'b1;
            tick(1);
        end
        ch_valid = '0;
        set_sw(0, 2, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            set_ch(0, 32'(200 + i));
            ch_valid[0] = 1'b1;
            tick(1);
        end
        ch_valid = '0;
        tick(3);
        // cap_sel=5, state=ARMED(1), wr_ptr=5
        checks++;
        if (debug_data !== 32'h2A5) begin
            failures++;
            $display("[TB] FAIL status_mid actual=%h expected=%h", debug_data, 32'h2A5);
        end
        checks++;
        if (armed !== 1'b1 || capture_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL status_mid_flags actual=%b%b expected=10", armed, capture_done);
        end
    endtask

    // Fill the buffer, then re-arm with a ch5 beat in the arm-edge cycle
    task automatic test_rearm_collision();
        for (int i = 5; i < 16; i++) begin
            set_ch(5, 32'(100 + i));
            ch_valid[5] = 1'b1;
            tick(1);
        end
        ch_valid = '0;
        checks++;
        if (capture_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL refill_done actual=%b expected=1", capture_done);
        end
        set_sw(5, 2, 0, 1'b0);
        tick(3);
        set_sw(5, 2, 0, 1'b1);
        tick(2);
        set_ch(5, 32'hDEAD0000);
        ch_valid[5] = 1'b1;
        tick(1);
        ch_valid = '0;
        checks++;
        if (armed !== 1'b1 || capture_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rearm_flags actual=%b%b expected=10", armed, capture_done);
        end
        tick(1);
        // cap_sel=5, state=ARMED(1), wr_ptr=0
        checks++;
        if (debug_data !== 32'h2A0) begin
            failures++;
            $display("[TB] FAIL rearm_status actual=%h expected=%h", debug_data, 32'h2A0);
        end
        set_sw(5, 3, 0, 1'b1);
        tick(3);
        checks++;
        if (debug_data !== 32'd100) begin
            failures++;
            $display("[TB] FAIL rearm_nowrite actual=%h expected=%h", debug_data, 32'd100);
        end
    endtask

    // Reset asserted between edges clears outputs at once; IDLE afterwards
    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (armed !== 1'b0 || capture_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL areset_flags actual=%b%b expected=00", armed, capture_done);
        end
        checks++;
        if (debug_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL areset_debug actual=%h expected=%h", debug_data, 32'h0);
        end
        set_sw(0, 2, 0, 1'b0);
        #3;
        rst = 1'b0;
        tick(3);
        checks++;
        if (debug_data !== 32'h0 || armed !== 1'b0) begin
            failures++;
            $display("[TB] FAIL areset_idle actual=%h/%b expected=0/0", debug_data, armed);
        end
    endtask

    // Run all scenarios in order and print the summary
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_live();
        test_freeze();
        test_capture();
        test_status_mid();
        test_rearm_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
